// File: rtl/remote_pad_responder_pkg.sv
// Definitions shared by both ends of the remote/pad serial link so that the
// master and the responder agree on frame length and state encoding.
package remote_pkg;

    localparam int DEF_NUM_BITS = 8;
    localparam int CNT_W        = $clog2(DEF_NUM_BITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_e;

endpackage

// File: rtl/remote_pad_responder_if.sv
// Pad-side pin bundle: latch/pulse from the master, parallel buttons in,
// serial data and status back out.
interface remote_pad_responder_if #(
    parameter int NUM_BITS = remote_pkg::DEF_NUM_BITS
);
    logic                Latch_In;
    logic                Pulse_In;
    logic [NUM_BITS-1:0] Buttons_In;
    logic                Data_Out;
    logic                Busy_Out;
    logic                Frame_Done_Out;

    modport master (
        output Latch_In, Pulse_In, Buttons_In,
        input  Data_Out, Busy_Out, Frame_Done_Out
    );

    modport slave (
        input  Latch_In, Pulse_In, Buttons_In,
        output Data_Out, Busy_Out, Frame_Done_Out
    );
endinterface

// File: rtl/remote_pad_responder_sync_edge.sv
// Multi-flop synchronizer for an asynchronous master line, followed by one
// history register so the rising edge is seen for exactly one clock.
module remote_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic synced,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];
    assign rise   = synced & ~prev_q;
endmodule

// File: rtl/remote_pad_responder.sv
// Controller-side responder: snapshots buttons on latch and shifts them out
// active-low, LSB first, one bit per master pulse.
module remote_pad_responder
    import remote_pkg::*;
#(
    parameter int   NUM_BITS    = DEF_NUM_BITS,
    parameter int   SYNC_STAGES = 2,
    parameter logic FILL_LEVEL  = 1'b1
) (
    input  logic                   Clk_In,
    input  logic                   Reset_In,
    remote_pad_responder_if.slave  pad
);
    localparam int BIT_CNT_W = $clog2(NUM_BITS + 1);

    logic [1:0] sync_lvl;
    logic [1:0] sync_rise;
    logic       latch_lvl;
    logic       latch_rise;
    logic       pulse_rise;
    logic       unused_pulse_lvl;

    // Index 0 is Latch, index 1 is Pulse.
    remote_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync [1:0] (
        .clk      (Clk_In),
        .rst_n    (Reset_In),
        .async_in ({pad.Pulse_In, pad.Latch_In}),
        .synced   (sync_lvl),
        .rise     (sync_rise)
    );

    assign latch_lvl        = sync_lvl[0];
    assign latch_rise       = sync_rise[0];
    assign pulse_rise       = sync_rise[1];
    assign unused_pulse_lvl = sync_lvl[1];

    state_e                state_q, state_n;
    logic [NUM_BITS-1:0]   shreg_q, shreg_n;
    logic [BIT_CNT_W-1:0]  cnt_q,   cnt_n;
    logic                  data_q,  data_n;
    logic                  done_q,  done_n;

    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            data_q  <= FILL_LEVEL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            shreg_q <= shreg_n;
            cnt_q   <= cnt_n;
            data_q  <= data_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n = state_q;
        shreg_n = shreg_q;
        cnt_n   = cnt_q;
        done_n  = 1'b0;
        // Output register follows the current state, which adds the final
        // cycle of pin-to-data latency.
        data_n  = (state_q == IDLE) ? FILL_LEVEL : shreg_q[0];

        // A latch edge wins over everything, including a coincident pulse.
        if (latch_rise) begin
            state_n = LOAD;
            shreg_n = ~pad.Buttons_In;
            cnt_n   = '0;
        end else begin
            case (state_q)
                IDLE: ;
                LOAD: begin
                    if (latch_lvl) begin
                        shreg_n = ~pad.Buttons_In;
                        cnt_n   = '0;
                    end else begin
                        state_n = SHIFT;
                    end
                end
                SHIFT: begin
                    if (pulse_rise) begin
                        shreg_n = NUM_BITS'({1'b1, shreg_q} >> 1);
                        cnt_n   = cnt_q + 1'b1;
                        if (cnt_q == BIT_CNT_W'(NUM_BITS - 1)) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign pad.Data_Out       = data_q;
    assign pad.Busy_Out       = (state_q != IDLE);
    assign pad.Frame_Done_Out = done_q;
endmodule

// File: tb/tb_remote_pad_responder.sv
// Directed bench for remote_pad_responder: stimulus queues expected pin values,
// a negedge monitor pops and compares them and accounts for every done pulse.
module tb_remote_pad_responder;
    localparam int NB = 8;

    typedef struct {
        string name;
        logic  data;
        logic  busy;
        logic  done;
    } exp_t;

    logic clk = 1'b0;
    logic Reset_In;
    always #5 clk = ~clk;

    remote_pad_responder_if #(.NUM_BITS(NB)) pad_if ();

    remote_pad_responder #(
        .NUM_BITS    (NB),
        .SYNC_STAGES (2),
        .FILL_LEVEL  (1'b1)
    ) dut (
        .Clk_In   (clk),
        .Reset_In (Reset_In),
        .pad      (pad_if)
    );

    exp_t  exp_q[$];
    string done_q[$];
    bit    finish_req = 1'b0;
    int    tests = 0;
    int    fails = 0;
    int    cycles = 0;

    // Monitor: the only process that touches the counters.
    always @(negedge clk) begin
        exp_t e;
        cycles++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (pad_if.Data_Out !== e.data || pad_if.Busy_Out !== e.busy ||
                pad_if.Frame_Done_Out !== e.done) begin
                fails++;
                $display("FAIL %s: got data=%b busy=%b done=%b, want data=%b busy=%b done=%b",
                         e.name, pad_if.Data_Out, pad_if.Busy_Out, pad_if.Frame_Done_Out,
                         e.data, e.busy, e.done);
            end
        end
        if (pad_if.Frame_Done_Out !== 1'b0) begin
            tests++;
            if (done_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: got done=%b, want 0 (no frame pending)",
                         pad_if.Frame_Done_Out);
            end else begin
                void'(done_q.pop_front());
            end
        end
        if (finish_req || cycles > 20000) begin
            tests++;
            if (cycles > 20000) begin
                fails++;
                $display("FAIL timeout: got %0d cycles, want <= 20000", cycles);
            end else if (done_q.size() != 0) begin
                fails++;
                $display("FAIL missing_done: got %0d frame-done pulses outstanding, want 0",
                         done_q.size());
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic d, input logic b, input logic dn);
        exp_t e;
        e.name = nm; e.data = d; e.busy = b; e.done = dn;
        exp_q.push_back(e);
    endtask

    // One master pulse; checks the old bit at edge 3 and the new bit at edge 4.
    task automatic pulse(input string nm, input logic d_old, input logic d_new,
                         input logic b, input logic last);
        pad_if.Pulse_In = 1'b1;
        if (last) done_q.push_back(nm);
        tick(3);
        chk({nm, "_pre"}, d_old, last ? 1'b0 : b, last);
        tick(1);
        chk(nm, last ? 1'b1 : d_new, last ? 1'b0 : b, 1'b0);
        pad_if.Pulse_In = 1'b0;
        tick(4);
    endtask

    task automatic latch(input string nm, input logic [NB-1:0] btn);
        pad_if.Buttons_In = btn;
        pad_if.Latch_In   = 1'b1;
        tick(4);
        chk({nm, "_load"}, ~btn[0], 1'b1, 1'b0);
        pad_if.Latch_In = 1'b0;
        tick(4);
        chk({nm, "_shift"}, ~btn[0], 1'b1, 1'b0);
    endtask

    task automatic run_frame(input string nm, input logic [NB-1:0] btn);
        logic nxt;
        for (int k = 1; k <= NB; k++) begin
            nxt = 1'b1;
            if (k < NB) nxt = ~btn[k];
            pulse($sformatf("%s_p%0d", nm, k), ~btn[k-1], nxt, 1'b1, k == NB);
        end
    endtask

    initial begin
        Reset_In          = 1'b0;
        pad_if.Latch_In   = 1'b0;
        pad_if.Pulse_In   = 1'b0;
        pad_if.Buttons_In = '0;

        // Reset held while the master lines toggle.
        for (int i = 0; i < 6; i++) begin
            pad_if.Latch_In = ~pad_if.Latch_In;
            pad_if.Pulse_In = (i % 3 == 0);
            tick(1);
            chk($sformatf("rst_hold%0d", i), 1'b1, 1'b0, 1'b0);
        end
        pad_if.Latch_In = 1'b0;
        pad_if.Pulse_In = 1'b0;
        tick(1);
        Reset_In = 1'b1;
        tick(8);
        chk("idle_after_rst", 1'b1, 1'b0, 1'b0);
        pulse("idle_pulse", 1'b1, 1'b1, 1'b0, 1'b0);

        // Full frame with exact latch latency.
        pad_if.Buttons_In = 8'b1000_0001;
        pad_if.Latch_In   = 1'b1;
        tick(3);
        chk("ff_latch_e3", 1'b1, 1'b1, 1'b0);
        tick(1);
        chk("ff_latch_e4", 1'b0, 1'b1, 1'b0);
        pad_if.Latch_In = 1'b0;
        tick(4);
        chk("ff_shift", 1'b0, 1'b1, 1'b0);
        run_frame("ff", 8'b1000_0001);
        tick(2);
        chk("ff_idle", 1'b1, 1'b0, 1'b0);

        // Live reload while latch is high; pulses during latch are ignored.
        pad_if.Buttons_In = 8'h00;
        pad_if.Latch_In   = 1'b1;
        tick(4);
        chk("live_first", 1'b1, 1'b1, 1'b0);
        pad_if.Pulse_In = 1'b1;
        tick(4);
        pad_if.Pulse_In = 1'b0;
        tick(4);
        chk("live_pulse_ign", 1'b1, 1'b1, 1'b0);
        pad_if.Buttons_In = 8'h01;
        tick(4);
        chk("live_update", 1'b0, 1'b1, 1'b0);
        pad_if.Latch_In = 1'b0;
        tick(4);
        chk("live_after_fall", 1'b0, 1'b1, 1'b0);
        run_frame("live", 8'h01);

        // Abort mid-frame with a fresh latch.
        latch("ab1", 8'hFF);
        for (int k = 1; k <= 3; k++)
            pulse($sformatf("ab1_p%0d", k), 1'b0, 1'b0, 1'b1, 1'b0);
        latch("ab2", 8'h00);
        run_frame("ab2", 8'h00);

        // Latch and pulse rising together while shifting: latch wins.
        latch("col0", 8'hAA);
        pad_if.Buttons_In = 8'h01;
        pad_if.Latch_In   = 1'b1;
        pad_if.Pulse_In   = 1'b1;
        tick(4);
        chk("col_load", 1'b0, 1'b1, 1'b0);
        pad_if.Pulse_In = 1'b0;
        tick(4);
        pad_if.Latch_In = 1'b0;
        tick(4);
        chk("col_shift", 1'b0, 1'b1, 1'b0);
        run_frame("col", 8'h01);

        // Reset in the middle of a frame acts immediately.
        latch("mr", 8'hFF);
        for (int k = 1; k <= 4; k++)
            pulse($sformatf("mr_p%0d", k), 1'b0, 1'b0, 1'b1, 1'b0);
        Reset_In = 1'b0;
        #1;
        chk("mr_async", 1'b1, 1'b0, 1'b0);
        tick(2);
        chk("mr_hold", 1'b1, 1'b0, 1'b0);
        Reset_In = 1'b1;
        tick(2);
        for (int k = 1; k <= 3; k++)
            pulse($sformatf("mr_post%0d", k), 1'b1, 1'b1, 1'b0, 1'b0);

        tick(5);
        finish_req = 1'b1;
    end
endmodule
